// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int ILEN = 32;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory, decode and redirect signals of the fetch unit; FETCH_MISALIGN_TRAP_EN adds fetch_misalign.
interface fetch_if #(parameter int XLEN = fetch_pkg::XLEN_DEF);
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_ready;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic inst_valid;
  logic [31:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic inst_ready;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misalign;
  modport master(output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_misalign,
                 input imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc);
  modport slave(input imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_misalign,
                output imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc);
`else
  modport master(output imem_req, imem_addr, inst_valid, inst, inst_pc,
                 input imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc);
  modport slave(input imem_req, imem_addr, inst_valid, inst, inst_pc,
                output imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc);
`endif
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction buffer; flush wins over push and pop.
module fetch_fifo #(
  parameter int BUF_DEPTH = 2,
  parameter int W = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH+1);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign full_o = cnt_q == CW'(BUF_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk)
    if (!rst_n || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding fetch_fifo.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirects and raise fetch_misalign.
module fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  state_e state_q, state_d, rq;
  logic [XLEN-1:0] pc_q, pc_d;
  logic go_q, mis_q, mis_d;
  logic accept, rsp, push, pop, full, empty, aligned, unused_full;
  logic [CW-1:0] count;
  logic [XLEN+ILEN-1:0] head;
  assign accept = bus.imem_req & bus.imem_ready;
  assign rsp = bus.imem_rvalid;
  assign pop = bus.inst_valid & bus.inst_ready;
  assign push = state_q == WAIT && rsp && !bus.redirect;
  assign unused_full = full;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign aligned = bus.redirect_pc[1:0] == 2'b00;
  assign bus.fetch_misalign = mis_q;
`else
  assign aligned = 1'b1;
`endif
  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH), .W(XLEN+ILEN)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(bus.redirect),
    .data_i({pc_q - XLEN'(4), bus.imem_rdata}), .data_o(head),
    .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_VEC;
      go_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      go_q <= 1'b1;
      mis_q <= mis_d;
    end
  // every path that would resume at REQ lands in HALT while a misaligned redirect is pending
  always_comb begin
    mis_d = bus.redirect ? !aligned : mis_q;
    pc_d = bus.redirect ? {bus.redirect_pc[XLEN-1:2], 2'b00} : accept ? pc_q + XLEN'(4) : pc_q;
    rq = mis_d ? HALT : REQ;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = go_q ? rq : IDLE;
      REQ: state_d = accept ? (bus.redirect ? DROP : WAIT) : (bus.redirect ? rq : REQ);
      WAIT: state_d = rsp ? rq : (bus.redirect ? DROP : WAIT);
      DROP: state_d = rsp ? rq : DROP;
      HALT: state_d = rq;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.imem_req = state_q == REQ && count < CW'(BUF_DEPTH);
    bus.imem_addr = pc_q;
    bus.inst_valid = !empty;
    {bus.inst_pc, bus.inst} = empty ? '0 : head;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_if #(.XLEN(32)) bus();
  fetch_if #(.XLEN(32)) bus2();
  fetch_unit #(.XLEN(32), .RESET_VEC(32'h0), .BUF_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.XLEN(32), .RESET_VEC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  int checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_a[$];
  int cnt = 0, stall_cnt = 0, stall_seen = 0, n_acc = 0, n2 = 0;
  logic [31:0] stall_addr = 32'h0, resp = 32'h0, addr = 32'h0;
  logic bad_en = 1'b0, bad_hit = 1'b0, acc = 1'b0, rs = 1'b0, acc2 = 1'b0;
  logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  function automatic logic [31:0] mem_data(logic [31:0] a);
    return 32'h0000_0013 | (a << 8);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic expect_pc(logic [31:0] pc);
    exp_q.push_back({pc, mem_data(pc)});
    exp_a.push_back(pc);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    step(3);
    exp_q.delete();
    exp_a.delete();
    n_acc = 0;
    stall_seen = 0;
    stall_cnt = 0;
    bad_en = 1'b0;
    bad_hit = 1'b0;
  endtask
  task automatic drain(string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_addr_left"}, 64'(exp_a.size()), 64'd0);
    bus.inst_ready = 1'b0;
  endtask
  // memory model: one-cycle response latency, optional stall and poisoned response at 0x8
  initial begin
    bus.imem_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      rs = rst_n;
      acc = rst_n && bus.imem_req && bus.imem_ready;
      addr = bus.imem_addr;
      if (bus.imem_req && !bus.imem_ready && bus.imem_addr == stall_addr) stall_seen++;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (!rs) cnt = 0;
      if (acc) begin
        n_acc++;
        if (exp_a.size() != 0) chk("imem_addr", 64'(addr), 64'(exp_a.pop_front()));
        cnt = (bad_en && addr == 32'h8) ? 3 : 1;
        resp = (bad_en && addr == 32'h8) ? 32'hDEAD_BEEF : mem_data(addr);
        if (bad_en && addr == 32'h8) begin
          bad_hit = 1'b1;
          bad_en = 1'b0;
        end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata = resp;
        end
      end
      bus.imem_ready = !(stall_cnt > 0 && bus.imem_req && bus.imem_addr == stall_addr);
      if (!bus.imem_ready) stall_cnt--;
    end
  end
  initial begin
    bus2.imem_ready = 1'b1;
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata = 32'h13;
    bus2.inst_ready = 1'b1;
    bus2.redirect = 1'b0;
    bus2.redirect_pc = 32'h0;
    forever begin
      @(negedge clk);
      acc2 = rst_n && bus2.imem_req;
      if (acc2 && n2 < 3) begin
        chk("wrap_addr", 64'(bus2.imem_addr), 64'(wrap_exp[n2]));
        n2++;
      end
      @(posedge clk);
      #1;
      bus2.imem_rvalid = acc2;
    end
  end
  always @(negedge clk) begin
    if (rst_n && bus.inst_valid && bus.inst == 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stale_inst: got %h expected any value but deadbeef", bus.inst);
    end
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", bus.inst_pc, bus.inst);
      end else chk("inst", {bus.inst_pc, bus.inst}, exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
    chk("rst_addr2", 64'(bus2.imem_addr), 64'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", 64'(bus.fetch_misalign), 64'd0);
`endif
    for (int a = 0; a < 16; a += 4) expect_pc(32'(a));
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("req_cycle1", 64'(bus.imem_req), 64'd0);
    step();
    chk("req_cycle2", 64'(bus.imem_req), 64'd1);
    drain("seq");
    do_reset();
    for (int a = 0; a < 12; a += 4) expect_pc(32'(a));
    rst_n = 1'b1;
    step(12);
    chk("full_accepts", 64'(n_acc), 64'd2);
    chk("full_req", 64'(bus.imem_req), 64'd0);
    chk("full_valid", 64'(bus.inst_valid), 64'd1);
    chk("full_head_pc", 64'(bus.inst_pc), 64'd0);
    step(3);
    chk("hold_head", {bus.inst_pc, bus.inst}, {32'h0, mem_data(32'h0)});
    chk("hold_accepts", 64'(n_acc), 64'd2);
    bus.inst_ready = 1'b1;
    drain("full");
    do_reset();
    for (int a = 0; a < 16; a += 4) expect_pc(32'(a));
    stall_addr = 32'h8;
    stall_cnt = 3;
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    drain("stall");
    chk("stall_cycles", 64'(stall_seen), 64'd3);
    do_reset();
    expect_pc(32'h0);
    expect_pc(32'h4);
    exp_a.push_back(32'h8);
    expect_pc(32'h100);
    expect_pc(32'h104);
    bad_en = 1'b1;
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 50 && !bad_hit; i++) step();
    chk("bad_hit", 64'(bad_hit), 64'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    chk("drop_req", 64'(bus.imem_req), 64'd0);
    chk("drop_valid", 64'(bus.inst_valid), 64'd0);
    step();
    chk("drop_req2", 64'(bus.imem_req), 64'd0);
    drain("redirect");
`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    exp_a.push_back(32'h0);
    exp_a.push_back(32'h4);
    rst_n = 1'b1;
    step(10);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 1'b0;
    chk("mis_flag", 64'(bus.fetch_misalign), 64'd1);
    chk("mis_req", 64'(bus.imem_req), 64'd0);
    chk("mis_valid", 64'(bus.inst_valid), 64'd0);
    step(3);
    chk("halt_req", 64'(bus.imem_req), 64'd0);
    chk("halt_flag", 64'(bus.fetch_misalign), 64'd1);
    expect_pc(32'h200);
    expect_pc(32'h204);
    bus.inst_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    chk("mis_clear", 64'(bus.fetch_misalign), 64'd0);
    drain("misalign");
`endif
    chk("wrap_count", 64'(n2), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, address/PC width; legal 32 or 64.
REQ-002 Parameter RESET_VEC, 0, first fetch address after reset; XLEN bits, word aligned.
REQ-003 Parameter BUF_DEPTH, 2, instruction buffer entries; power of two, 2..8.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  XLEN  fetch word address; low two bits always 00.
REQ-008 imem_ready  in  1  memory accepts request when high with imem_req.
REQ-009 imem_rvalid  in  1  response data valid.
REQ-010 imem_rdata  in  32  fetched instruction.
REQ-011 inst_valid  out  1  buffer head holds a valid instruction.
REQ-012 inst  out  32  head instruction.
REQ-013 inst_pc  out  XLEN  PC of head instruction.
REQ-014 inst_ready  in  1  decode consumes head when high with inst_valid.
REQ-015 redirect  in  1  flush and restart fetch (branch/jump/trap).
REQ-016 redirect_pc  in  XLEN  new fetch address.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DROP (plus HALT under REQ-033).
- IDLE -> REQ: unconditional, first cycle after reset release.
- REQ -> WAIT: imem_ready=1.
- WAIT -> REQ: imem_rvalid=1.
- DROP -> REQ: imem_rvalid=1.
REQ-018 At most one outstanding request.
- In REQ, imem_req=1 only when buffer count + outstanding < BUF_DEPTH.
- Otherwise imem_req=0 and state holds.
REQ-019 imem_addr equals fetch PC. Fetch PC increments by 4 on each accepted request (imem_req & imem_ready), modulo 2^XLEN with silent wrap.
REQ-020 Response in WAIT writes {PC, imem_rdata} to buffer tail in cycle N. inst_valid may rise no earlier than N+1 (no combinational bypass).
REQ-021 Head pops on inst_valid & inst_ready. inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
REQ-022 Buffer full: no request issued, imem_rdata never lost, since REQ-018 reserves a slot. Buffer empty: inst_valid=0.
REQ-023 Push and pop in the same cycle keep count unchanged, including at full and empty.
REQ-024 redirect has priority over all other events. In the next cycle:
- buffer empty;
- fetch PC = redirect_pc with bits [1:0] cleared;
- inst_valid=0.
REQ-025 redirect by state:
- In WAIT, or in REQ with imem_ready=1 the same cycle: next state DROP. The pending response is discarded on arrival, and the new fetch is issued only after it.
- In REQ with imem_ready=0: the request is withdrawn and the next request carries the new PC.
REQ-026 redirect and a pop in the same cycle: the pop counts as a completed handshake. A same-cycle imem_rvalid is discarded.
REQ-027 redirect in IDLE or DROP: updates PC; state sequencing otherwise unchanged.

Reset
REQ-028 While rst_n=0 at a rising edge, after that edge:
- state=IDLE;
- fetch PC=RESET_VEC;
- buffer empty;
- imem_req=0, imem_addr=RESET_VEC;
- inst_valid=0, inst=0, inst_pc=0.
REQ-029 Reset mid-transaction abandons any outstanding request. A response arriving during or after reset before the first new request is ignored.
REQ-030 First imem_req=1 occurs exactly 2 cycles after the first edge sampling rst_n=1: IDLE, then REQ.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN selects handling of misaligned redirects.
REQ-032 Without the macro: redirect_pc[1:0] are ignored (REQ-024) and no extra port exists.
REQ-033 With the macro:
- Extra output port fetch_misalign (1 bit, reset 0).
- A redirect with redirect_pc[1:0]!=0 enters HALT (via DROP if a response is pending) and sets fetch_misalign=1.
- In HALT, imem_req=0 and inst_valid=0.
- Only an aligned redirect clears fetch_misalign and resumes at REQ.

Structure
REQ-034 Package fetch_pkg holds the FSM state enum, ILEN=32, and the default XLEN.
REQ-035 Sub-module fetch_fifo (parameters BUF_DEPTH and width XLEN+32) holds the buffer. It has push, pop, flush, full, empty and count.

Verification
REQ-036 Reset release, zero-latency memory (imem_ready=1, rvalid the cycle after accept), inst_ready=1 -> imem_req first at cycle 2; inst_pc sequence 0,4,8,12.
REQ-037 inst_ready=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 entries buffered; imem_req=0 while full; on release, PCs 0,4,8 in order with none lost.
REQ-038 imem_ready low 3 cycles -> imem_addr stable at 0x8; no PC advance until accept.
REQ-039 Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on inst; next request address 0x100.
REQ-040 XLEN=32, RESET_VEC=0xFFFFFFF8 -> fetch addresses FFFFFFF8, FFFFFFFC, 00000000.
REQ-041 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misalign=1, imem_req=0; then redirect to 0x200 -> fetch_misalign=0, next request at 0x200.
